alu_seq_nbits: RTL

// - Parametrised N-bit sequential ALU, successor to the combinational display ALU.
// - Accepts operand pairs through a valid/ready handshake and registers them.
// - Runs single-cycle logic/arithmetic ops and multi-cycle iterative shifts.
// - Holds result, carry and zero flags until consumed; feeds the 7-segment display layer.

---
 rtl/alu_seq_nbits.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq_nbits.sv
// Sequential N-bit ALU with a valid/ready request side and a result held until acked.
// Optional macro ALU_SHIFT_FAST_EN swaps the iterative shifter for a barrel shifter.
module alu_seq_nbits #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  input  logic         invert_i,
  input  logic [3:0]   operacion_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [N-1:0] resultado_o,
  output logic         c_o,
  output logic         zero_o,
  output logic         valid_o,
  input  logic         ack_i
);

  localparam int SHW = $clog2(N);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, b_q, res_q;
  logic           c_q, inv_q, co_q;
  logic [3:0]     op_q;
  logic [SHW-1:0] cnt_q;
  logic [SHW-1:0] amtIn;
  logic [N-1:0]   bEff, aluRes;
  logic           aluCo;
  logic [N:0]     sum, diff;

  function automatic logic isShift(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

  assign amtIn = b_i[SHW-1:0];

  always_comb begin
    bEff   = inv_q ? ~b_q : b_q;
    sum    = {1'b0, a_q} + {1'b0, bEff} + {{N{1'b0}}, c_q};
    diff   = {1'b0, a_q} + {1'b0, ~bEff} + {{N{1'b0}}, 1'b1};
    aluRes = '0;
    aluCo  = 1'b0;
    case (op_q)
      OP_AND:  aluRes = a_q & bEff;
      OP_OR:   aluRes = a_q | bEff;
      OP_ADD:  begin aluRes = sum[N-1:0];  aluCo = sum[N];  end
      OP_SUB:  begin aluRes = diff[N-1:0]; aluCo = diff[N]; end
      OP_SLT:  aluRes[0] = $signed(a_q) < $signed(bEff);
      OP_SLTU: aluRes[0] = a_q < bEff;
`ifdef ALU_SHIFT_FAST_EN
      OP_SRL:  aluRes = a_q >> b_q[SHW-1:0];
      OP_SLL:  aluRes = a_q << b_q[SHW-1:0];
      OP_SRA:  aluRes = $signed(a_q) >>> b_q[SHW-1:0];
`endif
      default: aluRes = '0;
    endcase
  end

`ifndef ALU_SHIFT_FAST_EN
  logic [N-1:0] shOne;

  // One-bit step of the iterative shifter; a_q doubles as the shift register.
  always_comb begin
    shOne = a_q;
    case (op_q)
      OP_SRL:  shOne = {1'b0, a_q[N-1:1]};
      OP_SLL:  shOne = {a_q[N-2:0], 1'b0};
      OP_SRA:  shOne = {a_q[N-1], a_q[N-1:1]};
      default: shOne = a_q;
    endcase
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
`ifdef ALU_SHIFT_FAST_EN
          state_d = EXEC;
`else
          if (isShift(operacion_i)) state_d = (amtIn == '0) ? DONE : SHIFT;
          else                      state_d = EXEC;
`endif
        end
      end
      EXEC:    state_d = DONE;
      SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
      DONE:    if (ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o     = (state_q == IDLE);
    valid_o     = (state_q == DONE);
    resultado_o = res_q;
    c_o         = co_q;
    zero_o      = (res_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      inv_q <= 1'b0;
      op_q  <= '0;
      res_q <= '0;
      co_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            c_q   <= c_i;
            inv_q <= invert_i;
            op_q  <= operacion_i;
            cnt_q <= amtIn;
`ifndef ALU_SHIFT_FAST_EN
            // A zero-amount shift skips SHIFT and publishes A directly.
            if (isShift(operacion_i) && (amtIn == '0)) begin
              res_q <= a_i;
              co_q  <= 1'b0;
            end
`endif
          end
        end
        EXEC: begin
          res_q <= aluRes;
          co_q  <= aluCo;
        end
        SHIFT: begin
`ifndef ALU_SHIFT_FAST_EN
          a_q   <= shOne;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            res_q <= shOne;
            co_q  <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
